// File: rtl/seven_segment_pkg.sv
// Shared types, decode table and polarity helper for seven-segment display blocks.
package seven_segment_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned NIB_W = 4;

   typedef logic [SEG_W-1:0] seg_t;

   // Active-high lit pattern per hex digit, bit6=a ... bit0=g.
   localparam seg_t HEX_TO_SEG [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   function automatic seg_t seg_polarity(input seg_t s, input bit active_low);
      return active_low ? ~s : s;
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-high seven-segment pattern.
module seg_hex_decode
   import seven_segment_pkg::*;
(
   input  logic [NIB_W-1:0] nibble,
   output seg_t             seg_c
);

   always_comb begin
      seg_c = HEX_TO_SEG[nibble];
   end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed seven-segment scanner with shadow capture and per-slot anti-ghost blanking.
// Optional leading-zero suppression enabled by defining SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN.
module seven_segment_scan
   import seven_segment_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned BLANK_CYCLES   = 16,
   parameter int unsigned SEG_ACTIVE_LOW = 1,
   parameter int unsigned AN_ACTIVE_LOW  = 1
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NIB_W*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]       dp_in,
   input  logic                        load,
   input  logic                        blank,
   output seg_t                        seg,
   output logic                        dp,
   output logic [NUM_DIGITS-1:0]       an
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned VAL_W = NIB_W * NUM_DIGITS;
   localparam bit          SEG_LOW = (SEG_ACTIVE_LOW != 0);
   localparam bit          AN_LOW  = (AN_ACTIVE_LOW != 0);
   localparam seg_t                  SEG_OFF = {SEG_W{SEG_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_LOW}};

   logic [VAL_W-1:0]      shadow_val;
   logic [NUM_DIGITS-1:0] shadow_dp;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      idx;

   logic [NIB_W-1:0]      nib_c;
   logic                  dp_sel_c;
   logic                  lz_c;
   logic [NUM_DIGITS-1:0] lz_mask_c;
   logic                  in_guard_c;
   logic                  an_on_c;
   logic [NUM_DIGITS-1:0] onehot_c;
   seg_t                  dec_c;

   // Shadow capture plus free-running slot counter and digit index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_val <= '0;
         shadow_dp  <= '0;
         cnt        <= '0;
         idx        <= '0;
      end else begin
         if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp_in;
         end
         if (cnt == CNT_W'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
   // A digit is suppressed when it and every digit above it are zero and its dp is off.
   logic above_zero_c;
   always_comb begin
      lz_mask_c    = '0;
      above_zero_c = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         above_zero_c = above_zero_c && (shadow_val[NIB_W*i +: NIB_W] == '0);
         lz_mask_c[i] = above_zero_c && !shadow_dp[i];
      end
   end
`else
   assign lz_mask_c = '0;
`endif

   always_comb begin
      nib_c    = '0;
      dp_sel_c = 1'b0;
      lz_c     = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            nib_c    = shadow_val[NIB_W*i +: NIB_W];
            dp_sel_c = shadow_dp[i];
            lz_c     = lz_mask_c[i];
         end
      end
   end

   generate
      if (BLANK_CYCLES == 0) begin : g_no_guard
         assign in_guard_c = 1'b0;
      end else begin : g_guard
         assign in_guard_c = (cnt < CNT_W'(BLANK_CYCLES));
      end
   endgenerate

   seg_hex_decode u_dec (
      .nibble (nib_c),
      .seg_c  (dec_c)
   );

   assign an_on_c  = !in_guard_c && !blank && !lz_c;
   assign onehot_c = NUM_DIGITS'(1) << idx;

   // Pin registers with polarity applied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= SEG_OFF;
         dp  <= SEG_LOW;
         an  <= AN_OFF;
      end else begin
         seg <= seg_polarity(dec_c, SEG_LOW);
         dp  <= dp_sel_c ^ SEG_LOW;
         an  <= (an_on_c ? onehot_c : '0) ^ AN_OFF;
      end
   end

endmodule
